// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl
//   Command/config controller that sits behind the UART receiver. Incoming
//   byte strobes are assembled into 4-byte frames {HEADER, ADDR, DATA, CHK}.
//   A valid frame either writes one of four registers or reprograms the
//   receiver baud select. A malformed or stalled frame is flagged and dropped.
//
//   Optional feature macro: UART_CMD_STATS_EN
//     defined   -> err_cnt counts frame_err pulses, saturating at 8'hFF
//     undefined -> err_cnt is tied to 8'h00 (port list unchanged)
//
// Ports
//   sysclk     in   1  system clock
//   rst        in   1  asynchronous reset, active-high
//   rx_data    in   8  received byte, valid with rx_done
//   rx_done    in   1  one-cycle byte-received strobe
//   baud_set   out  3  baud code to receiver (0=115200 .. 4=9600)
//   reg_wr_en  out  1  one-cycle register write strobe
//   reg_addr   out  2  register index, held until the next write
//   reg_wdata  out  8  register write data, held until the next write
//   frame_ok   out  1  one-cycle pulse, frame accepted
//   frame_err  out  1  one-cycle pulse, checksum/address/baud/timeout error
//   busy       out  1  frame partially received
//   err_cnt    out  8  saturating error count (see macro above)
//
// State | meaning
// ------+---------------------------------------------------
// IDLE  | hunting for HEADER, other bytes silently ignored
// ADDR  | HEADER seen, waiting for the address byte
// DATA  | address latched, waiting for the data byte
// CHK   | data latched, waiting for the checksum byte

module uart_rx_cmd_ctrl #(
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         TIMEOUT_CYC = 50000,
   parameter logic [7:0] BAUD_ADDR   = 8'h7F
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [2:0] baud_set,
   output logic       reg_wr_en,
   output logic [1:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       busy,
   output logic [7:0] err_cnt
);

   // The counter never passes TIMEOUT_CYC-1: it is cleared on the expiry edge.
   localparam int            CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_CHK
   } state_t;

   state_t        state;
   logic [7:0]    addr_q;
   logic [7:0]    data_q;
   logic [CW-1:0] tmo_cnt;
   logic [7:0]    chk_sum;
   logic          tmo_hit;

   assign chk_sum = addr_q + data_q;
   // A byte arriving on the expiry cycle takes priority over the timeout.
   assign tmo_hit = (state != S_IDLE) && !rx_done && (tmo_cnt == TMO_LAST);
   assign busy    = (state != S_IDLE);

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         addr_q    <= 8'h00;
         data_q    <= 8'h00;
         tmo_cnt   <= '0;
         baud_set  <= 3'd0;
         reg_wr_en <= 1'b0;
         reg_addr  <= 2'd0;
         reg_wdata <= 8'h00;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;

         if (state == S_IDLE || rx_done || tmo_hit)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + CW'(1);

         if (tmo_hit) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
         end else if (rx_done) begin
            case (state)
               S_IDLE: begin
                  if (rx_data == HEADER)
                     state <= S_ADDR;
               end
               S_ADDR: begin
                  addr_q <= rx_data;
                  state  <= S_DATA;
               end
               S_DATA: begin
                  data_q <= rx_data;
                  state  <= S_CHK;
               end
               S_CHK: begin
                  state <= S_IDLE;
                  if (rx_data != chk_sum) begin
                     frame_err <= 1'b1;
                  end else if (addr_q <= 8'd3) begin
                     reg_wr_en <= 1'b1;
                     reg_addr  <= addr_q[1:0];
                     reg_wdata <= data_q;
                     frame_ok  <= 1'b1;
                  end else if (addr_q == BAUD_ADDR && data_q <= 8'd4) begin
                     baud_set <= data_q[2:0];
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef UART_CMD_STATS_EN
   // Counts each frame_err pulse on the edge after it is visible.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst)
         err_cnt <= 8'h00;
      else if (frame_err && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end
`else
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
module tb_uart_rx_cmd_ctrl;

   localparam int         TMO = 40;
   localparam logic [7:0] HDR = 8'hA5;

   logic       sysclk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [2:0] baud_set;
   logic       reg_wr_en;
   logic [1:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       frame_ok;
   logic       frame_err;
   logic       busy;
   logic [7:0] err_cnt;

   uart_rx_cmd_ctrl #(.HEADER(HDR), .TIMEOUT_CYC(TMO), .BAUD_ADDR(8'h7F)) dut (
      .sysclk    (sysclk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .baud_set  (baud_set),
      .reg_wr_en (reg_wr_en),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .busy      (busy),
      .err_cnt   (err_cnt)
   );

   always #5 sysclk = ~sysclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the frame is a queue of bytes since HEADER; silence is
   // the number of byte-free cycles since the last byte of a pending frame.
   logic [7:0] fq[$];
   int         silent;
   int         err_total;
   logic       exp_wr, exp_ok, exp_err, exp_busy;
   logic [1:0] exp_addr;
   logic [7:0] exp_wdata, exp_errcnt;
   logic [2:0] exp_baud;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      silent     = 0;
      err_total  = 0;
      exp_wr     = 1'b0;
      exp_ok     = 1'b0;
      exp_err    = 1'b0;
      exp_busy   = 1'b0;
      exp_addr   = 2'd0;
      exp_wdata  = 8'h00;
      exp_errcnt = 8'h00;
      exp_baud   = 3'd0;
   endtask

   task automatic model_eval_frame();
      logic [7:0] a, d, c, s;
      a = fq[1];
      d = fq[2];
      c = fq[3];
      s = 8'((int'(a) + int'(d)) % 256);
      if (c != s) begin
         exp_err = 1'b1;
      end else if (a < 8'd4) begin
         exp_wr    = 1'b1;
         exp_ok    = 1'b1;
         exp_addr  = a[1:0];
         exp_wdata = d;
      end else if (a == 8'h7F && d <= 8'd4) begin
         exp_ok   = 1'b1;
         exp_baud = d[2:0];
      end else begin
         exp_err = 1'b1;
      end
   endtask

   task automatic model_update(input logic dv, input logic [7:0] d);
      if (exp_err && err_total < 255) err_total++;
`ifdef UART_CMD_STATS_EN
      exp_errcnt = 8'(err_total);
`else
      exp_errcnt = 8'h00;
`endif
      exp_wr  = 1'b0;
      exp_ok  = 1'b0;
      exp_err = 1'b0;
      if (dv) begin
         silent = 0;
         if (fq.size() == 0) begin
            if (d == HDR) fq.push_back(d);
         end else begin
            fq.push_back(d);
            if (fq.size() == 4) begin
               model_eval_frame();
               fq.delete();
            end
         end
      end else if (fq.size() != 0) begin
         silent++;
         if (silent == TMO) begin
            exp_err = 1'b1;
            fq.delete();
            silent = 0;
         end
      end
      exp_busy = (fq.size() != 0);
   endtask

   task automatic check_all();
      check_eq("reg_wr_en", reg_wr_en, exp_wr);
      check_eq("reg_addr",  reg_addr,  exp_addr);
      check_eq("reg_wdata", reg_wdata, exp_wdata);
      check_eq("frame_ok",  frame_ok,  exp_ok);
      check_eq("frame_err", frame_err, exp_err);
      check_eq("baud_set",  baud_set,  exp_baud);
      check_eq("busy",      busy,      exp_busy);
      check_eq("err_cnt",   err_cnt,   exp_errcnt);
      check_eq("ok_err_excl", frame_ok & frame_err, 1'b0);
   endtask

   // One clock: check what the last edge produced, then drive the next input.
   task automatic step(input logic dv, input logic [7:0] d);
      @(negedge sysclk);
      check_all();
      rx_done = dv;
      rx_data = d;
      model_update(dv, d);
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      step(1'b1, d);
      repeat (gap) step(1'b0, 8'h00);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      send_byte(HDR, 0);
      send_byte(a, 0);
      send_byte(d, 0);
      send_byte(c, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      check_all();
      rst     = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      model_reset();
      repeat (2) @(negedge sysclk);
      check_all();
      rst = 1'b0;
   endtask

   function automatic int rgap();
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) return TMO - 1;
      if (r == 1) return TMO;
      return r % 4;
   endfunction

   initial begin
      int         kind;
      logic [7:0] a, d, c, b;

      rst     = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      model_reset();
      repeat (3) @(negedge sysclk);
      check_all();
      rst = 1'b0;

      // 1: register write
      send_frame(8'h02, 8'h3C, 8'h3E);
      idle(3);
      check_eq("t1_reg_addr", reg_addr, 2'd2);
      check_eq("t1_reg_wdata", reg_wdata, 8'h3C);

      // 2: baud accept then reject
      send_frame(8'h7F, 8'h04, 8'h83);
      idle(2);
      check_eq("t2_baud_ok", baud_set, 3'd4);
      send_frame(8'h7F, 8'h05, 8'h84);
      idle(2);
      check_eq("t2_baud_hold", baud_set, 3'd4);

      // 3: bad checksum then good frame back-to-back
      send_frame(8'h01, 8'h10, 8'h00);
      send_frame(8'h01, 8'h10, 8'h11);
      idle(2);
      check_eq("t3_reg_addr", reg_addr, 2'd1);
      check_eq("t3_reg_wdata", reg_wdata, 8'h10);

      // 4: junk before header, header value inside payload
      send_byte(8'h00, 1);
      send_byte(8'hFF, 0);
      send_frame(8'h00, 8'hAA, 8'hAA);
      idle(2);
      check_eq("t4_reg_addr", reg_addr, 2'd0);
      send_frame(8'h03, HDR, 8'hA8);
      idle(2);
      check_eq("t4_hdr_as_data", reg_wdata, HDR);

      // 5: timeout, then a byte exactly on the expiry cycle
      send_byte(HDR, 0);
      send_byte(8'h03, TMO);
      idle(2);
      check_eq("t5_busy_after_tmo", busy, 1'b0);
      send_byte(HDR, 0);
      send_byte(8'h03, TMO - 1);
      send_byte(8'h44, TMO - 1);
      send_byte(8'h47, 2);
      check_eq("t5_edge_wdata", reg_wdata, 8'h44);

      // 6: reset mid-frame discards it
      send_byte(HDR, 0);
      send_byte(8'h03, 1);
      do_reset();
      check_eq("t6_rst_busy", busy, 1'b0);
      send_frame(8'h01, 8'h22, 8'h23);
      idle(2);
      check_eq("t6_reg_wdata", reg_wdata, 8'h22);

      // randomized frames with junk, bad checksums and timeout-boundary gaps
      for (int f = 0; f < 400; f++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            b = 8'($urandom);
            if (b == HDR) b = 8'h00;
            send_byte(b, rgap());
         end else begin
            case ($urandom_range(0, 3))
               0, 1:    a = 8'($urandom_range(0, 3));
               2:       a = 8'h7F;
               default: a = 8'($urandom);
            endcase
            d = (a == 8'h7F) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            c = a + d;
            if ($urandom_range(0, 4) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
            send_byte(HDR, rgap());
            send_byte(a, rgap());
            send_byte(d, rgap());
            send_byte(c, rgap());
         end
      end
      idle(4);

      // error statistics: 300 bad frames saturate the counter when enabled
      for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h10, 8'h00);
      idle(4);
`ifdef UART_CMD_STATS_EN
      check_eq("stats_sat", err_cnt, 8'hFF);
`else
      check_eq("stats_off", err_cnt, 8'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
